// File: rtl/pong_pixel_renderer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pong_pixel_renderer : Pong game state and per-pixel RGB, one stage behind timing
// Optional: PONG_SCORE_BAR_EN draws green score bars on the top rows.  Rev 1.0
// ---------------------------------------------------------------------------
module pong_pixel_renderer #(
    parameter int H_RES        = 800,
    parameter int V_RES        = 600,
    parameter int PADDLE_W     = 8,
    parameter int PADDLE_H     = 80,
    parameter int PAD_OFF      = 16,
    parameter int BALL_SIZE    = 8,
    parameter int BALL_SPEED   = 4,
    parameter int PADDLE_SPEED = 6,
    parameter int SERVE_FRAMES = 60,
    parameter int WIN_SCORE    = 9
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [11:0] nextX,
    input  logic [11:0] nextY,
    input  logic        blank_n,
    input  logic        hSync_n,
    input  logic        vSync_n,
    input  logic        upL,
    input  logic        dnL,
    input  logic        upR,
    input  logic        dnR,
    output logic [7:0]  red,
    output logic [7:0]  green,
    output logic [7:0]  blue,
    output logic        blankOut_n,
    output logic        hSyncOut_n,
    output logic        vSyncOut_n,
    output logic [3:0]  scoreL,
    output logic [3:0]  scoreR
);

    typedef logic signed [12:0] coord_t;

    localparam coord_t c_ZERO     = coord_t'(0);
    localparam coord_t c_PAD_Y0   = coord_t'((V_RES - PADDLE_H) / 2);
    localparam coord_t c_PAD_MAX  = coord_t'(V_RES - PADDLE_H);
    localparam coord_t c_PAD_H    = coord_t'(PADDLE_H);
    localparam coord_t c_PADL_X   = coord_t'(PAD_OFF);
    localparam coord_t c_PADR_X   = coord_t'(H_RES - PAD_OFF - PADDLE_W);
    localparam coord_t c_PAD_W    = coord_t'(PADDLE_W);
    localparam coord_t c_BX0      = coord_t'((H_RES - BALL_SIZE) / 2);
    localparam coord_t c_BY0      = coord_t'((V_RES - BALL_SIZE) / 2);
    localparam coord_t c_BX_MAX   = coord_t'(H_RES - BALL_SIZE);
    localparam coord_t c_BY_MAX   = coord_t'(V_RES - BALL_SIZE);
    localparam coord_t c_FACE_L   = coord_t'(PAD_OFF + PADDLE_W);
    localparam coord_t c_FACE_R   = coord_t'(H_RES - PAD_OFF - PADDLE_W - BALL_SIZE);
    localparam coord_t c_BSZ      = coord_t'(BALL_SIZE);
    localparam coord_t c_BSPD     = coord_t'(BALL_SPEED);
    localparam coord_t c_PSPD     = coord_t'(PADDLE_SPEED);
    localparam coord_t c_MID      = coord_t'(H_RES / 2);
    localparam coord_t c_MID_M1   = coord_t'(H_RES / 2 - 1);
    localparam logic [11:0] c_XLAST = 12'(H_RES - 1);
    localparam logic [11:0] c_YLAST = 12'(V_RES - 1);
    localparam int          c_CW    = $clog2(SERVE_FRAMES + 1);
    localparam logic [c_CW-1:0] c_SERVE_LAST = c_CW'(SERVE_FRAMES - 1);
    localparam logic [3:0]  c_WIN   = 4'(WIN_SCORE);

    localparam logic [1:0] c_ST_SERVE = 2'd0;
    localparam logic [1:0] c_ST_PLAY  = 2'd1;
    localparam logic [1:0] c_ST_OVER  = 2'd2;

    logic              r_tick;
    logic [1:0]        r_state;
    logic [c_CW-1:0]   r_serve_cnt;
    coord_t            r_pad_l, r_pad_r, r_ball_x, r_ball_y;
    logic              r_dx, r_dy;           // 1 = moving toward larger coordinate
    logic [3:0]        r_score_l, r_score_r;

    logic [1:0]        w_state_nxt;
    logic [c_CW-1:0]   w_cnt_nxt;
    coord_t            w_pad_l_nxt, w_pad_r_nxt, w_bx_nxt, w_by_nxt;
    coord_t            w_cand_x, w_cand_y;
    logic              w_dx_nxt, w_dy_nxt;
    logic [3:0]        w_sl_nxt, w_sr_nxt;
    logic              w_ovl_l, w_ovl_r;
    logic              w_tick_in;

    function automatic coord_t f_paddle_step(input coord_t pos, input logic up, input logic dn);
        coord_t cand;
        cand = pos;
        if (up && !dn)
            cand = pos - c_PSPD;
        else if (dn && !up)
            cand = pos + c_PSPD;
        if (cand < c_ZERO)
            cand = c_ZERO;
        else if (cand > c_PAD_MAX)
            cand = c_PAD_MAX;
        return cand;
    endfunction

    assign w_tick_in = blank_n && (nextX == c_XLAST) && (nextY == c_YLAST);
    assign w_cand_x  = r_dx ? (r_ball_x + c_BSPD) : (r_ball_x - c_BSPD);
    assign w_cand_y  = r_dy ? (r_ball_y + c_BSPD) : (r_ball_y - c_BSPD);
    assign w_ovl_l   = (r_ball_y + c_BSZ > r_pad_l) && (r_ball_y < r_pad_l + c_PAD_H);
    assign w_ovl_r   = (r_ball_y + c_BSZ > r_pad_r) && (r_ball_y < r_pad_r + c_PAD_H);
    assign w_pad_l_nxt = f_paddle_step(r_pad_l, upL, dnL);
    assign w_pad_r_nxt = f_paddle_step(r_pad_r, upR, dnR);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_serve_cnt;
        w_bx_nxt    = r_ball_x;
        w_by_nxt    = r_ball_y;
        w_dx_nxt    = r_dx;
        w_dy_nxt    = r_dy;
        w_sl_nxt    = r_score_l;
        w_sr_nxt    = r_score_r;
        case (r_state)
            c_ST_SERVE: begin
                w_bx_nxt = c_BX0;
                w_by_nxt = c_BY0;
                if (r_serve_cnt == c_SERVE_LAST) begin
                    w_state_nxt = c_ST_PLAY;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_serve_cnt + 1'b1;
                end
            end
            c_ST_PLAY: begin
                if (w_cand_y <= c_ZERO) begin
                    w_by_nxt = c_ZERO;
                    w_dy_nxt = 1'b1;
                end else if (w_cand_y >= c_BY_MAX) begin
                    w_by_nxt = c_BY_MAX;
                    w_dy_nxt = 1'b0;
                end else begin
                    w_by_nxt = w_cand_y;
                end
                // A miss recentres the ball and overrides the vertical result above
                if (!r_dx) begin
                    if (w_cand_x <= c_FACE_L && w_ovl_l) begin
                        w_bx_nxt = c_FACE_L;
                        w_dx_nxt = 1'b1;
                    end else if (w_cand_x < c_ZERO) begin
                        w_sr_nxt    = r_score_r + 1'b1;
                        w_dx_nxt    = 1'b0;
                        w_bx_nxt    = c_BX0;
                        w_by_nxt    = c_BY0;
                        w_cnt_nxt   = '0;
                        w_state_nxt = (w_sr_nxt == c_WIN) ? c_ST_OVER : c_ST_SERVE;
                    end else begin
                        w_bx_nxt = w_cand_x;
                    end
                end else begin
                    if (w_cand_x >= c_FACE_R && w_ovl_r) begin
                        w_bx_nxt = c_FACE_R;
                        w_dx_nxt = 1'b0;
                    end else if (w_cand_x > c_BX_MAX) begin
                        w_sl_nxt    = r_score_l + 1'b1;
                        w_dx_nxt    = 1'b1;
                        w_bx_nxt    = c_BX0;
                        w_by_nxt    = c_BY0;
                        w_cnt_nxt   = '0;
                        w_state_nxt = (w_sl_nxt == c_WIN) ? c_ST_OVER : c_ST_SERVE;
                    end else begin
                        w_bx_nxt = w_cand_x;
                    end
                end
            end
            c_ST_OVER: begin
                w_bx_nxt = c_BX0;
                w_by_nxt = c_BY0;
            end
            default: begin
                w_state_nxt = c_ST_SERVE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_tick      <= 1'b0;
            r_state     <= c_ST_SERVE;
            r_serve_cnt <= '0;
            r_pad_l     <= c_PAD_Y0;
            r_pad_r     <= c_PAD_Y0;
            r_ball_x    <= c_BX0;
            r_ball_y    <= c_BY0;
            r_dx        <= 1'b1;
            r_dy        <= 1'b1;
            r_score_l   <= 4'd0;
            r_score_r   <= 4'd0;
        end else begin
            r_tick <= w_tick_in;
            if (r_tick) begin
                r_state     <= w_state_nxt;
                r_serve_cnt <= w_cnt_nxt;
                r_pad_l     <= w_pad_l_nxt;
                r_pad_r     <= w_pad_r_nxt;
                r_ball_x    <= w_bx_nxt;
                r_ball_y    <= w_by_nxt;
                r_dx        <= w_dx_nxt;
                r_dy        <= w_dy_nxt;
                r_score_l   <= w_sl_nxt;
                r_score_r   <= w_sr_nxt;
            end
        end
    end

    coord_t w_px, w_py;
    logic   w_hit_ball, w_hit_pad, w_hit_bar, w_hit_mid;

    assign w_px = coord_t'({1'b0, nextX});
    assign w_py = coord_t'({1'b0, nextY});

    assign w_hit_ball = (r_state != c_ST_OVER)
                     && (w_px >= r_ball_x) && (w_px < r_ball_x + c_BSZ)
                     && (w_py >= r_ball_y) && (w_py < r_ball_y + c_BSZ);
    assign w_hit_pad  = ((w_px >= c_PADL_X) && (w_px < c_PADL_X + c_PAD_W)
                         && (w_py >= r_pad_l) && (w_py < r_pad_l + c_PAD_H))
                     || ((w_px >= c_PADR_X) && (w_px < c_PADR_X + c_PAD_W)
                         && (w_py >= r_pad_r) && (w_py < r_pad_r + c_PAD_H));
    assign w_hit_mid  = ((w_px == c_MID_M1) || (w_px == c_MID)) && !nextY[4];

`ifdef PONG_SCORE_BAR_EN
    localparam coord_t c_BAR_L     = coord_t'(32);
    localparam coord_t c_BAR_R_END = coord_t'(H_RES - 32);
    localparam coord_t c_BAR_ROWS  = coord_t'(8);
    coord_t w_bar_l_end, w_bar_r_beg;
    assign w_bar_l_end = c_BAR_L + coord_t'({5'b0, r_score_l, 4'b0000});
    assign w_bar_r_beg = c_BAR_R_END - coord_t'({5'b0, r_score_r, 4'b0000});
    assign w_hit_bar   = (w_py < c_BAR_ROWS)
                      && (((w_px >= c_BAR_L) && (w_px < w_bar_l_end))
                       || ((w_px >= w_bar_r_beg) && (w_px < c_BAR_R_END)));
`else
    assign w_hit_bar = 1'b0;
`endif

    always_ff @(posedge Clock) begin
        if (Reset) begin
            red        <= 8'h00;
            green      <= 8'h00;
            blue       <= 8'h00;
            blankOut_n <= 1'b0;
            hSyncOut_n <= 1'b1;
            vSyncOut_n <= 1'b1;
        end else begin
            blankOut_n <= blank_n;
            hSyncOut_n <= hSync_n;
            vSyncOut_n <= vSync_n;
            if (!blank_n) begin
                {red, green, blue} <= 24'h000000;
            end else if (w_hit_ball || w_hit_pad) begin
                {red, green, blue} <= 24'hFFFFFF;
            end else if (w_hit_bar) begin
                {red, green, blue} <= 24'h00FF00;
            end else if (w_hit_mid) begin
                {red, green, blue} <= 24'h808080;
            end else begin
                {red, green, blue} <= 24'h000000;
            end
        end
    end

    assign scoreL = r_score_l;
    assign scoreR = r_score_r;

endmodule
`default_nettype wire

// File: tb/tb_pong_pixel_renderer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_pong_pixel_renderer : self-checking bench with a frame-level game model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_pong_pixel_renderer;
    localparam int H = 800, V = 600, PW = 8, PH = 80, POFF = 16, BS = 8;
    localparam int BSPD = 4, PSPD = 6, SERVE = 60, WIN = 9;

    logic        Clock = 1'b0, Reset = 1'b1;
    logic [11:0] nextX = '0, nextY = '0;
    logic        blank_n = 1'b0, hSync_n = 1'b1, vSync_n = 1'b1;
    logic        upL = 1'b0, dnL = 1'b0, upR = 1'b0, dnR = 1'b0;
    logic [7:0]  red, green, blue;
    logic        blankOut_n, hSyncOut_n, vSyncOut_n;
    logic [3:0]  scoreL, scoreR;

    pong_pixel_renderer dut (
        .Clock(Clock), .Reset(Reset), .nextX(nextX), .nextY(nextY),
        .blank_n(blank_n), .hSync_n(hSync_n), .vSync_n(vSync_n),
        .upL(upL), .dnL(dnL), .upR(upR), .dnR(dnR),
        .red(red), .green(green), .blue(blue),
        .blankOut_n(blankOut_n), .hSyncOut_n(hSyncOut_n), .vSyncOut_n(vSyncOut_n),
        .scoreL(scoreL), .scoreR(scoreR)
    );

    always #5 Clock = ~Clock;

    int n_checks = 0, n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Game model: 0 = serving, 1 = rally, 2 = game over
    int m_state, m_cnt, m_padL, m_padR, m_bx, m_by, m_dx, m_dy, m_sL, m_sR;
    bit m_pend, m_valid = 1'b0;
    int exp_rgb, exp_syn;

    function automatic bit inside_box(int x, int y, int x0, int y0, int w, int h);
        return x >= x0 && x < x0 + w && y >= y0 && y < y0 + h;
    endfunction

    function automatic int color_at(int x, int y);
        if (m_state != 2 && inside_box(x, y, m_bx, m_by, BS, BS)) return 'hFFFFFF;
        if (inside_box(x, y, POFF, m_padL, PW, PH)) return 'hFFFFFF;
        if (inside_box(x, y, H - POFF - PW, m_padR, PW, PH)) return 'hFFFFFF;
`ifdef PONG_SCORE_BAR_EN
        if (y < 8 && ((x >= 32 && x < 32 + 16 * m_sL) || (x >= H - 32 - 16 * m_sR && x < H - 32)))
            return 'h00FF00;
`endif
        if ((x == H / 2 - 1 || x == H / 2) && ((y / 16) % 2 == 0)) return 'h808080;
        return 0;
    endfunction

    function automatic int paddle_move(int y, bit up, bit dn);
        int n = y;
        if (up && !dn) n = y - PSPD;
        if (dn && !up) n = y + PSPD;
        if (n < 0) n = 0;
        if (n > V - PH) n = V - PH;
        return n;
    endfunction

    task automatic model_reset();
        m_state = 0; m_cnt = 0;
        m_padL = (V - PH) / 2; m_padR = (V - PH) / 2;
        m_bx = (H - BS) / 2; m_by = (V - BS) / 2;
        m_dx = 1; m_dy = 1; m_sL = 0; m_sR = 0; m_pend = 0;
    endtask

    task automatic model_frame();
        int cx, cy, nx, ny, ndx, ndy;
        bit hitL, hitR, missL, missR;
        if (m_state == 0) begin
            m_cnt++;
            if (m_cnt == SERVE) begin m_state = 1; m_cnt = 0; end
        end else if (m_state == 1) begin
            cx = m_bx + BSPD * m_dx;
            cy = m_by + BSPD * m_dy;
            ny = cy; ndy = m_dy; nx = cx; ndx = m_dx;
            if (cy <= 0) begin ny = 0; ndy = 1; end
            else if (cy >= V - BS) begin ny = V - BS; ndy = -1; end
            hitL  = m_by + BS > m_padL && m_by < m_padL + PH;
            hitR  = m_by + BS > m_padR && m_by < m_padR + PH;
            missL = 0; missR = 0;
            if (m_dx < 0) begin
                if (cx <= POFF + PW && hitL) begin nx = POFF + PW; ndx = 1; end
                else if (cx < 0) missL = 1;
            end else begin
                if (cx >= H - POFF - PW - BS && hitR) begin nx = H - POFF - PW - BS; ndx = -1; end
                else if (cx > H - BS) missR = 1;
            end
            m_dy = ndy;
            if (missL || missR) begin
                if (missL) begin m_sR++; m_dx = -1; end
                else begin m_sL++; m_dx = 1; end
                m_bx = (H - BS) / 2; m_by = (V - BS) / 2; m_cnt = 0;
                m_state = (m_sL == WIN || m_sR == WIN) ? 2 : 0;
            end else begin
                m_bx = nx; m_by = ny; m_dx = ndx;
            end
        end
        m_padL = paddle_move(m_padL, upL, dnL);
        m_padR = paddle_move(m_padR, upR, dnR);
    endtask

    // Outputs registered at this edge are what the model predicts here
    always @(posedge Clock) begin
        if (Reset) begin
            model_reset();
            exp_rgb = 0;
            exp_syn = 3'b011;
        end else begin
            exp_rgb = blank_n ? color_at(int'(nextX), int'(nextY)) : 0;
            exp_syn = {29'd0, blank_n, hSync_n, vSync_n};
            if (m_pend) model_frame();
            m_pend = blank_n && nextX == 12'(H - 1) && nextY == 12'(V - 1);
        end
        m_valid = 1'b1;
    end

    always @(negedge Clock) begin
        if (m_valid) begin
            chk("rgb", {8'd0, red, green, blue}, exp_rgb);
            chk("syncs", {29'd0, blankOut_n, hSyncOut_n, vSyncOut_n}, exp_syn);
            chk("scores", {24'd0, scoreL, scoreR}, {24'd0, m_sL[3:0], m_sR[3:0]});
        end
    end

    task automatic cyc(input int x, input int y, input bit bl);
        nextX = 12'(x); nextY = 12'(y); blank_n = bl;
        @(negedge Clock); #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) cyc(H - 1, V - 1, 1'b1);
        cyc(0, 0, 1'b0);
    endtask

    task automatic probe(input string name, input int x, input int y, input int exp);
        cyc(x, y, 1'b1);
        chk(name, {8'd0, red, green, blue}, exp);
    endtask

    initial begin
        int r, x, y;
        #1;
        Reset = 1'b1;
        cyc(396, 296, 1'b1);
        cyc(396, 296, 1'b1);
        chk("reset_rgb", {8'd0, red, green, blue}, 0);
        chk("reset_syncs", {29'd0, blankOut_n, hSyncOut_n, vSyncOut_n}, 3'b011);
        chk("reset_scores", {24'd0, scoreL, scoreR}, 0);
        Reset = 1'b0;

        ticks(1);
        chk("model_padL_260", m_padL, 260);
        chk("model_ball_x_396", m_bx, 396);
        chk("model_ball_y_296", m_by, 296);
        probe("ball_topleft", 396, 296, 'hFFFFFF);
        probe("ball_botright", 403, 303, 'hFFFFFF);
        probe("ball_right_edge", 404, 296, 0);
        probe("padL_top", 16, 260, 'hFFFFFF);
        probe("padL_above", 16, 259, 0);
        probe("padR_bottom", 783, 339, 'hFFFFFF);
        probe("padR_right", 784, 339, 0);
        probe("centre_line_on", 399, 0, 'h808080);
        probe("centre_line_gap", 400, 16, 0);

        hSync_n = 1'b0; vSync_n = 1'b1;
        cyc(10, 300, 1'b0);
        chk("blank_rgb", {8'd0, red, green, blue}, 0);
        chk("blank_syncs", {29'd0, blankOut_n, hSyncOut_n, vSyncOut_n}, 3'b001);
        hSync_n = 1'b1; vSync_n = 1'b0;
        cyc(16, 300, 1'b0);
        chk("blank_syncs2", {29'd0, blankOut_n, hSyncOut_n, vSyncOut_n}, 3'b010);
        vSync_n = 1'b1;

        upL = 1'b1;
        ticks(50);
        upL = 1'b0;
        chk("model_padL_clamp", m_padL, 0);
        probe("padL_at_0", 16, 0, 'hFFFFFF);
        probe("padL_row79", 16, 79, 'hFFFFFF);
        probe("padL_row80", 16, 80, 0);
        probe("padL_nowrap", 16, 4095, 0);

        // Undisturbed right paddle: ball misses exactly 100 frames into each rally
        ticks(108);
        chk("scoreL_before_miss", {28'd0, scoreL}, 0);
        ticks(1);
        chk("scoreL_first_miss", {28'd0, scoreL}, 1);
        probe("ball_recentred", 396, 296, 'hFFFFFF);
        ticks(1280);
        chk("scoreL_win", {28'd0, scoreL}, 9);
        chk("scoreR_win", {28'd0, scoreR}, 0);
        ticks(30);
        chk("scores_frozen", {24'd0, scoreL, scoreR}, 8'h90);
        probe("ball_hidden", 396, 296, 0);
        dnL = 1'b1;
        ticks(10);
        dnL = 1'b0;
        probe("padL_moves_over", 16, 60, 'hFFFFFF);
        probe("padL_over_above", 16, 59, 0);

        Reset = 1'b1;
        cyc(16, 70, 1'b1);
        chk("midreset_rgb", {8'd0, red, green, blue}, 0);
        Reset = 1'b0;
        chk("midreset_scores", {24'd0, scoreL, scoreR}, 0);
        probe("midreset_pad", 16, 260, 'hFFFFFF);

        for (int i = 0; i < 20000; i++) begin
            if ($urandom_range(0, 7) == 0) {upL, dnL, upR, dnR} = 4'($urandom);
            Reset   = ($urandom_range(0, 2999) == 0);
            hSync_n = 1'($urandom);
            vSync_n = 1'($urandom);
            r = $urandom_range(0, 9);
            if (r < 4) begin
                cyc(H - 1, V - 1, 1'b1);
            end else begin
                if (r < 7) begin
                    x = m_bx - 4 + $urandom_range(0, 15);
                    y = m_by - 4 + $urandom_range(0, 15);
                end else if (r == 7) begin
                    x = ($urandom_range(0, 1) != 0) ? $urandom_range(12, 28) : $urandom_range(770, 790);
                    y = $urandom_range(0, V - 1);
                end else begin
                    x = $urandom_range(0, 4095);
                    y = $urandom_range(0, 1023);
                end
                if (x < 0) x = 0;
                if (y < 0) y = 0;
                cyc(x, y, $urandom_range(0, 7) != 0);
            end
        end
        Reset = 1'b0;
        cyc(0, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
